riscv_bp_resolve: RTL and testbench

//  Write-side companion of the branch prediction unit. Takes branches resolved in EX,

---
 rtl/riscv_bp_resolve_if.sv | 52 +++++
 rtl/riscv_bp_resolve.sv | 120 ++++++++++++
 tb/tb_riscv_bp_resolve.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_bp_resolve_if.sv
// Resolve-side bundle between EX, the branch resolve block and the predictor write port.
// Statistics signals exist only when RISCV_BP_STATS_EN is defined.
interface riscv_bp_resolve_if #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BP_GLOBAL_BITS = 2
`ifdef RISCV_BP_STATS_EN
    ,parameter int unsigned STAT_BITS     = 32
`endif
);
    logic                      ex_valid;
    logic                      ex_is_branch;
    logic                      ex_stall;
    logic                      flush;
    logic [XLEN-1:0]           ex_pc;
    logic [BP_GLOBAL_BITS-1:0] ex_bp_history;
    logic [1:0]                ex_bp_predict;
    logic                      ex_btaken;
    logic                      bp_ready;

    logic                      bu_bp_update;
    logic [XLEN-1:0]           bu_pc;
    logic [BP_GLOBAL_BITS-1:0] bu_bp_history;
    logic [1:0]                bu_bp_predict;
    logic                      bu_bp_btaken;
    logic                      bu_mispredict;
    logic [BP_GLOBAL_BITS-1:0] if_bp_history;
`ifdef RISCV_BP_STATS_EN
    logic [STAT_BITS-1:0]      stat_branches;
    logic [STAT_BITS-1:0]      stat_mispredicts;
    logic [STAT_BITS-1:0]      stat_dropped;
`endif

    modport master (
        output ex_valid, ex_is_branch, ex_stall, flush, ex_pc, ex_bp_history,
               ex_bp_predict, ex_btaken, bp_ready,
        input  bu_bp_update, bu_pc, bu_bp_history, bu_bp_predict, bu_bp_btaken,
               bu_mispredict, if_bp_history
`ifdef RISCV_BP_STATS_EN
        ,input stat_branches, stat_mispredicts, stat_dropped
`endif
    );

    modport slave (
        input  ex_valid, ex_is_branch, ex_stall, flush, ex_pc, ex_bp_history,
               ex_bp_predict, ex_btaken, bp_ready,
        output bu_bp_update, bu_pc, bu_bp_history, bu_bp_predict, bu_bp_btaken,
               bu_mispredict, if_bp_history
`ifdef RISCV_BP_STATS_EN
        ,output stat_branches, stat_mispredicts, stat_dropped
`endif
    );
endinterface

// File: rtl/riscv_bp_resolve.sv
// Branch resolve: GHR maintenance, mispredict detection and buffered predictor updates.
// Optional saturating statistics counters enabled by RISCV_BP_STATS_EN.
module riscv_bp_resolve #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BP_GLOBAL_BITS = 2,
    parameter int unsigned UPD_DEPTH      = 4
`ifdef RISCV_BP_STATS_EN
    ,parameter int unsigned STAT_BITS     = 32
`endif
) (
    input logic               clk_i,
    input logic               rst_i,
    riscv_bp_resolve_if.slave bp
);
    localparam int unsigned AW = $clog2(UPD_DEPTH);

    typedef struct packed {
        logic [XLEN-1:0]           pc;
        logic [BP_GLOBAL_BITS-1:0] history;
        logic [1:0]                predict;
        logic                      btaken;
    } upd_t;

    upd_t                      mem [UPD_DEPTH];
    upd_t                      head;
    logic [AW:0]               wr_ptr;
    logic [AW:0]               rd_ptr;
    logic [BP_GLOBAL_BITS-1:0] ghr;
    logic [BP_GLOBAL_BITS-1:0] ghr_next;
    logic                      mispredict;
    logic                      resolve;
    logic                      miss;
    logic                      empty;
    logic                      full;
    logic                      push;
    logic                      pop;

    always_comb begin
        resolve = bp.ex_valid & bp.ex_is_branch & ~bp.ex_stall & ~bp.flush;
        miss    = bp.ex_bp_predict[1] != bp.ex_btaken;
        empty   = wr_ptr == rd_ptr;
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop     = ~empty & bp.bp_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push    = resolve & (~full | pop);
    end

    generate
        if (BP_GLOBAL_BITS == 1) begin : g_ghr_one
            assign ghr_next = bp.ex_btaken;
        end else begin : g_ghr_shift
            assign ghr_next = {ghr[BP_GLOBAL_BITS-2:0], bp.ex_btaken};
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ghr        <= '0;
            mispredict <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            for (int unsigned i = 0; i < UPD_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            mispredict <= resolve & miss;
            if (resolve) begin
                ghr <= ghr_next;
            end
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= '{pc: bp.ex_pc, history: bp.ex_bp_history,
                                          predict: bp.ex_bp_predict, btaken: bp.ex_btaken};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign head             = mem[rd_ptr[AW-1:0]];
    assign bp.bu_bp_update  = pop;
    assign bp.bu_pc         = head.pc;
    assign bp.bu_bp_history = head.history;
    assign bp.bu_bp_predict = head.predict;
    assign bp.bu_bp_btaken  = head.btaken;
    assign bp.bu_mispredict = mispredict;
    assign bp.if_bp_history = ghr;

`ifdef RISCV_BP_STATS_EN
    logic [STAT_BITS-1:0] n_branches;
    logic [STAT_BITS-1:0] n_mispredicts;
    logic [STAT_BITS-1:0] n_dropped;
    logic                 drop;

    assign drop = resolve & full & ~pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            n_branches    <= '0;
            n_mispredicts <= '0;
            n_dropped     <= '0;
        end else begin
            if (resolve && n_branches != '1) begin
                n_branches <= n_branches + 1'b1;
            end
            if (resolve && miss && n_mispredicts != '1) begin
                n_mispredicts <= n_mispredicts + 1'b1;
            end
            if (drop && n_dropped != '1) begin
                n_dropped <= n_dropped + 1'b1;
            end
        end
    end

    assign bp.stat_branches    = n_branches;
    assign bp.stat_mispredicts = n_mispredicts;
    assign bp.stat_dropped     = n_dropped;
`endif
endmodule

// File: tb/tb_riscv_bp_resolve.sv
// Directed bench for riscv_bp_resolve: queue-based reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_riscv_bp_resolve;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned BG    = 2;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

`ifdef RISCV_BP_STATS_EN
    riscv_bp_resolve_if #(.XLEN(XLEN), .BP_GLOBAL_BITS(BG), .STAT_BITS(32)) intf ();
    riscv_bp_resolve #(.XLEN(XLEN), .BP_GLOBAL_BITS(BG), .UPD_DEPTH(DEPTH), .STAT_BITS(32)) dut (
        .clk_i(clk), .rst_i(rst), .bp(intf.slave));
`else
    riscv_bp_resolve_if #(.XLEN(XLEN), .BP_GLOBAL_BITS(BG)) intf ();
    riscv_bp_resolve #(.XLEN(XLEN), .BP_GLOBAL_BITS(BG), .UPD_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .bp(intf.slave));
`endif

    typedef struct {
        int unsigned pc;
        int unsigned hist;
        int unsigned pred;
        int unsigned taken;
    } entry_t;

    entry_t      mq[$];
    int unsigned m_ghr = 0;
    int unsigned m_mis = 0;
    int unsigned m_br = 0, m_mp = 0, m_drop = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending updates and integer history.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ghr = 0; m_mis = 0; m_br = 0; m_mp = 0; m_drop = 0;
        end else begin
            bit res;
            res = intf.ex_valid && intf.ex_is_branch && !intf.ex_stall && !intf.flush;
            if (mq.size() != 0 && intf.bp_ready) void'(mq.pop_front());
            m_mis = 0;
            if (res) begin
                m_ghr = (m_ghr * 2 + intf.ex_btaken) % (1 << BG);
                m_mis = (intf.ex_bp_predict[1] != intf.ex_btaken) ? 1 : 0;
                m_br++;
                if (m_mis != 0) m_mp++;
                if (mq.size() < DEPTH)
                    mq.push_back('{pc: intf.ex_pc, hist: intf.ex_bp_history,
                                   pred: intf.ex_bp_predict, taken: intf.ex_btaken});
                else
                    m_drop++;
            end
        end
    end

    always @(negedge clk) begin
        bit exp_upd;
        exp_upd = (mq.size() != 0) && intf.bp_ready && !rst;
        check("ghr", intf.if_bp_history, m_ghr);
        check("mispredict", intf.bu_mispredict, m_mis);
        check("update", intf.bu_bp_update, exp_upd);
        if (exp_upd) begin
            check("head_pc", intf.bu_pc, mq[0].pc);
            check("head_hist", intf.bu_bp_history, mq[0].hist);
            check("head_pred", intf.bu_bp_predict, mq[0].pred);
            check("head_taken", intf.bu_bp_btaken, mq[0].taken);
        end
`ifdef RISCV_BP_STATS_EN
        check("stat_branches", intf.stat_branches, m_br);
        check("stat_mispredicts", intf.stat_mispredicts, m_mp);
        check("stat_dropped", intf.stat_dropped, m_drop);
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        intf.ex_valid = 0; intf.ex_is_branch = 0; intf.ex_stall = 0; intf.flush = 0;
        intf.ex_pc = '0; intf.ex_bp_history = '0; intf.ex_bp_predict = '0; intf.ex_btaken = 0;
    endtask

    task automatic branch(input int unsigned pc, input int unsigned hist,
                          input int unsigned pred, input bit taken);
        intf.ex_valid = 1; intf.ex_is_branch = 1; intf.ex_stall = 0; intf.flush = 0;
        intf.ex_pc = pc; intf.ex_bp_history = hist[BG-1:0];
        intf.ex_bp_predict = pred[1:0]; intf.ex_btaken = taken;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit tk [5];
        tk = '{1, 0, 1, 1, 0};
        idle();
        intf.bp_ready = 0;
        repeat (2) cyc();
        check("rst_update", intf.bu_bp_update, 0);
        check("rst_mispredict", intf.bu_mispredict, 0);
        check("rst_ghr", intf.if_bp_history, 0);
        check("rst_pc", intf.bu_pc, 0);
        rst = 0;

        // 1: single mispredicted resolve, drained immediately
        branch(32'h200, 0, 0, 1); intf.bp_ready = 1;
        cyc(); idle();
        check("t1_mispredict", intf.bu_mispredict, 1);
        check("t1_ghr", intf.if_bp_history, 2'b01);
        check("t1_update", intf.bu_bp_update, 1);
        check("t1_pc", intf.bu_pc, 32'h200);
        check("t1_pred", intf.bu_bp_predict, 0);
        check("t1_taken", intf.bu_bp_btaken, 1);
        cyc();
        check("t1_mis_clear", intf.bu_mispredict, 0);

        // 2: fill with port stalled, drop the fifth, drain in order
        intf.bp_ready = 0;
        for (int k = 0; k < 5; k++) begin
            branch(32'h100 + 4 * k, k, 2'b10, tk[k]);
            cyc();
        end
        idle();
        check("t2_ghr", intf.if_bp_history, 2'b10);
`ifdef RISCV_BP_STATS_EN
        check("t2_dropped", intf.stat_dropped, 1);
`endif
        intf.bp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t2_update", intf.bu_bp_update, 1);
            check("t2_pc", intf.bu_pc, 32'h100 + 4 * k);
            check("t2_taken", intf.bu_bp_btaken, tk[k]);
            cyc();
        end
        #1 check("t2_empty", intf.bu_bp_update, 0);

        // 3: full FIFO with simultaneous push and pop, then a drop proves it stayed full
        intf.bp_ready = 0;
        for (int k = 0; k < 4; k++) begin
            branch(32'h300 + 4 * k, 1, 2'b11, 1);
            cyc();
        end
        branch(32'h310, 2, 2'b11, 1); intf.bp_ready = 1;
        cyc();
        check("t3_head", intf.bu_pc, 32'h304);
        branch(32'h314, 3, 2'b11, 1); intf.bp_ready = 0;
        cyc(); idle();
`ifdef RISCV_BP_STATS_EN
        check("t3_dropped", intf.stat_dropped, 2);
`endif
        intf.bp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1 check("t3_pc", intf.bu_pc, 32'h304 + 4 * k);
            cyc();
        end
        #1 check("t3_empty", intf.bu_bp_update, 0);

        // 4: stalled and flushed branches have no effect; queued entries survive flush
        branch(32'h400, 0, 2'b11, 0); intf.ex_stall = 1;
        cyc();
        check("t4_stall_ghr", intf.if_bp_history, 2'b11);
        check("t4_stall_mis", intf.bu_mispredict, 0);
        check("t4_stall_upd", intf.bu_bp_update, 0);
        intf.bp_ready = 0;
        branch(32'h404, 0, 2'b11, 1);
        cyc();
        branch(32'h408, 0, 2'b11, 0); intf.flush = 1;
        cyc(); idle();
        check("t4_flush_ghr", intf.if_bp_history, 2'b11);
        check("t4_flush_mis", intf.bu_mispredict, 0);
        intf.bp_ready = 1;
        #1 check("t4_kept_pc", intf.bu_pc, 32'h404);
        cyc();
        #1 check("t4_kept_empty", intf.bu_bp_update, 0);

        // 5: GHR sequence from reset
        rst = 1; cyc(); rst = 0;
        branch(32'h500, 0, 2'b11, 1); cyc();
        check("t5_ghr0", intf.if_bp_history, 2'b01);
        check("t5_mis0", intf.bu_mispredict, 0);
        branch(32'h504, 1, 2'b11, 1); cyc();
        check("t5_ghr1", intf.if_bp_history, 2'b11);
        check("t5_mis1", intf.bu_mispredict, 0);
        branch(32'h508, 3, 2'b11, 0); cyc(); idle();
        check("t5_ghr2", intf.if_bp_history, 2'b10);
        check("t5_mis2", intf.bu_mispredict, 1);
        cyc();

        // 6: asynchronous reset in the middle of a drain
        intf.bp_ready = 0;
        for (int k = 0; k < 3; k++) begin
            branch(32'h600 + 4 * k, 0, 2'b01, 1);
            cyc();
        end
        idle(); intf.bp_ready = 1;
        #1 check("t6_pre_update", intf.bu_bp_update, 1);
        #1 rst = 1;
        #1;
        check("t6_rst_update", intf.bu_bp_update, 0);
        check("t6_rst_ghr", intf.if_bp_history, 0);
        repeat (2) cyc();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("t6_post_update", intf.bu_bp_update, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
